// File: rtl/riscv_branch_unit_pkg.sv
// Purpose: shared opcode, funct3 and PC-mux encodings for the branch resolution stage.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package riscv_branch_unit_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] SEL_PC4    = 2'b00;
    localparam logic [1:0] SEL_PCIMM  = 2'b01;
    localparam logic [1:0] SEL_RS1IMM = 2'b10;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } br_state_t;

endpackage

// File: rtl/riscv_branch_cmp.sv
// Purpose: conditional-branch comparator; decides taken/illegal from funct3 and rs1/rs2.
// Latency: purely combinational.
// Backpressure: none, no state.
// Ports: funct3 (branch condition), rs1/rs2 (operands), taken (condition true), illegal (funct3 010/011).
module riscv_branch_cmp
    import riscv_branch_unit_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [2:0]    funct3,
    input  logic [DW-1:0] rs1,
    input  logic [DW-1:0] rs2,
    output logic          taken,
    output logic          illegal
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1 == rs2);
    assign lt_s = ($signed(rs1) < $signed(rs2));
    assign lt_u = (rs1 < rs2);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = !eq;
            F3_BLT:  taken = lt_s;
            F3_BGE:  taken = !lt_s;
            F3_BLTU: taken = lt_u;
            F3_BGEU: taken = !lt_u;
            default: illegal = 1'b1;   // 010 / 011 are unassigned encodings
        endcase
    end

endmodule

// File: rtl/riscv_branch_unit.sv
// Purpose: registered RV32I branch/jump resolution with mispredict flush window and perf counters.
// Latency: 1 cycle from accept to Valid_o; Flush_o rises with Mispredict_o for FLUSH_CYCLES cycles.
// Backpressure: Ready_o low while Stall_i is high or a flush is in progress; stall freezes outputs.
// Ports: clk_i/rst_i (sync active-high); Valid_i/Ready_o handshake; Opcode_i, funct3_i,
//        Regdata1_i, Regdata2_i, PC_i, Imm_i, Pred_taken_i instruction fields; Stall_i downstream hold;
//        Valid_o, Branch_en_o, PC_mux_sel_o, Target_o, Link_o, Mispredict_o, Illegal_o, Flush_o results;
//        Br_count_o, Mispred_count_o saturating counters.
module riscv_branch_unit
    import riscv_branch_unit_pkg::*;
#(
    parameter int DW           = 32,
    parameter int AW           = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CW           = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          Valid_i,
    output logic          Ready_o,
    input  logic [6:0]    Opcode_i,
    input  logic [2:0]    funct3_i,
    input  logic [DW-1:0] Regdata1_i,
    input  logic [DW-1:0] Regdata2_i,
    input  logic [AW-1:0] PC_i,
    input  logic [DW-1:0] Imm_i,
    input  logic          Pred_taken_i,
    input  logic          Stall_i,
    output logic          Valid_o,
    output logic          Branch_en_o,
    output logic [1:0]    PC_mux_sel_o,
    output logic [AW-1:0] Target_o,
    output logic [AW-1:0] Link_o,
    output logic          Mispredict_o,
    output logic          Illegal_o,
    output logic          Flush_o,
    output logic [CW-1:0] Br_count_o,
    output logic [CW-1:0] Mispred_count_o
);

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    br_state_t      state, state_nx;
    logic [FCW-1:0] flush_cnt, flush_cnt_nx;
    logic           accept;

    logic           cmp_taken;
    logic           cmp_illegal;

    logic [AW-1:0]  imm_aw;
    logic [AW-1:0]  pc_plus4;
    logic [AW-1:0]  pc_plus_imm;
    logic [AW-1:0]  rs1_plus_imm;

    logic           nx_taken;
    logic           nx_illegal;
    logic           nx_ctrl;      // legal control-transfer op, counted in Br_count_o
    logic           nx_mispred;
    logic [1:0]     nx_sel;
    logic [AW-1:0]  nx_target;

    riscv_branch_cmp #(.DW(DW)) u_cmp (
        .funct3  (funct3_i),
        .rs1     (Regdata1_i),
        .rs2     (Regdata2_i),
        .taken   (cmp_taken),
        .illegal (cmp_illegal)
    );

    assign Ready_o = (state == ST_RUN) && !Stall_i;
    assign accept  = Valid_i && Ready_o;
    assign Flush_o = (state == ST_FLUSH);

    // Immediate is sign-extended (or truncated) to address width; sums wrap mod 2^AW.
    assign imm_aw       = AW'($signed(Imm_i));
    assign pc_plus4     = PC_i + AW'(4);
    assign pc_plus_imm  = PC_i + imm_aw;
    assign rs1_plus_imm = (AW'(Regdata1_i) + imm_aw) & ~AW'(1);

    always_comb begin
        nx_taken   = 1'b0;
        nx_illegal = 1'b0;
        nx_ctrl    = 1'b0;
        nx_sel     = SEL_PC4;
        case (Opcode_i)
            OP_JAL: begin
                nx_taken = 1'b1;
                nx_ctrl  = 1'b1;
                nx_sel   = SEL_PCIMM;
            end
            OP_JALR: begin
                nx_taken = 1'b1;
                nx_ctrl  = 1'b1;
                nx_sel   = SEL_RS1IMM;
            end
            OP_BRANCH: begin
                if (cmp_illegal) begin
                    nx_illegal = 1'b1;
                end else begin
                    nx_ctrl  = 1'b1;
                    nx_taken = cmp_taken;
                    if (cmp_taken) begin
                        nx_sel = SEL_PCIMM;
                    end
                end
            end
            default: ;
        endcase

        case (nx_sel)
            SEL_PCIMM:  nx_target = pc_plus_imm;
            SEL_RS1IMM: nx_target = rs1_plus_imm;
            default:    nx_target = pc_plus4;
        endcase

        // Non-control ops are "not taken", so a taken prediction on them is a mispredict too.
        nx_mispred = nx_illegal ? 1'b0 : (nx_taken != Pred_taken_i);
    end

    // Flush FSM: runs independently of Stall_i so a stall never stretches the window.
    always_comb begin
        state_nx     = state;
        flush_cnt_nx = flush_cnt;
        case (state)
            ST_RUN: begin
                if (accept && nx_mispred) begin
                    state_nx     = ST_FLUSH;
                    flush_cnt_nx = FCW'(FLUSH_CYCLES - 1);
                end
            end
            ST_FLUSH: begin
                if (flush_cnt == '0) begin
                    state_nx = ST_RUN;
                end else begin
                    flush_cnt_nx = flush_cnt - FCW'(1);
                end
            end
            default: state_nx = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_nx;
            flush_cnt <= flush_cnt_nx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            Valid_o         <= 1'b0;
            Branch_en_o     <= 1'b0;
            PC_mux_sel_o    <= SEL_PC4;
            Target_o        <= '0;
            Link_o          <= '0;
            Mispredict_o    <= 1'b0;
            Illegal_o       <= 1'b0;
            Br_count_o      <= '0;
            Mispred_count_o <= '0;
        end else if (!Stall_i) begin
            if (accept) begin
                Valid_o      <= 1'b1;
                Branch_en_o  <= nx_taken;
                PC_mux_sel_o <= nx_sel;
                Target_o     <= nx_target;
                Link_o       <= pc_plus4;
                Mispredict_o <= nx_mispred;
                Illegal_o    <= nx_illegal;
                if (nx_ctrl && (Br_count_o != '1)) begin
                    Br_count_o <= Br_count_o + CW'(1);
                end
                if (nx_mispred && (Mispred_count_o != '1)) begin
                    Mispred_count_o <= Mispred_count_o + CW'(1);
                end
            end else begin
                Valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_riscv_branch_unit.sv
// Purpose: randomized + directed self-checking bench for riscv_branch_unit against a behavioural model.
// Latency: model predicts results one clock after each accept.
// Backpressure: Stall_i and flush windows exercised randomly and in directed cases.
module tb_riscv_branch_unit;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int FLUSH = 2;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_ALU    = 7'b0110011;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          Valid_i;
    logic          Ready_o;
    logic [6:0]    Opcode_i;
    logic [2:0]    funct3_i;
    logic [DW-1:0] Regdata1_i;
    logic [DW-1:0] Regdata2_i;
    logic [AW-1:0] PC_i;
    logic [DW-1:0] Imm_i;
    logic          Pred_taken_i;
    logic          Stall_i;
    logic          Valid_o;
    logic          Branch_en_o;
    logic [1:0]    PC_mux_sel_o;
    logic [AW-1:0] Target_o;
    logic [AW-1:0] Link_o;
    logic          Mispredict_o;
    logic          Illegal_o;
    logic          Flush_o;
    logic [CW-1:0] Br_count_o;
    logic [CW-1:0] Mispred_count_o;

    riscv_branch_unit #(.DW(DW), .AW(AW), .FLUSH_CYCLES(FLUSH), .CW(CW)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .Valid_i         (Valid_i),
        .Ready_o         (Ready_o),
        .Opcode_i        (Opcode_i),
        .funct3_i        (funct3_i),
        .Regdata1_i      (Regdata1_i),
        .Regdata2_i      (Regdata2_i),
        .PC_i            (PC_i),
        .Imm_i           (Imm_i),
        .Pred_taken_i    (Pred_taken_i),
        .Stall_i         (Stall_i),
        .Valid_o         (Valid_o),
        .Branch_en_o     (Branch_en_o),
        .PC_mux_sel_o    (PC_mux_sel_o),
        .Target_o        (Target_o),
        .Link_o          (Link_o),
        .Mispredict_o    (Mispredict_o),
        .Illegal_o       (Illegal_o),
        .Flush_o         (Flush_o),
        .Br_count_o      (Br_count_o),
        .Mispred_count_o (Mispred_count_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: expected visible outputs plus remaining flush cycles.
    logic          m_valid, m_br, m_mis, m_ill;
    logic [1:0]    m_sel;
    logic [31:0]   m_tgt, m_link;
    int            m_flush_left;
    int            m_brc, m_mpc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_br = 0; m_mis = 0; m_ill = 0; m_sel = 0;
        m_tgt = 0; m_link = 0; m_flush_left = 0; m_brc = 0; m_mpc = 0;
    endtask

    task automatic model_accept();
        logic tk, ill, ctl;
        logic [1:0]  sel;
        logic [31:0] tgt;
        tk = 0; ill = 0; ctl = 0; sel = 2'd0;
        tgt = PC_i + 32'd4;
        if (Opcode_i == T_JAL) begin
            tk = 1; ctl = 1; sel = 2'd1; tgt = PC_i + Imm_i;
        end else if (Opcode_i == T_JALR) begin
            tk = 1; ctl = 1; sel = 2'd2; tgt = (Regdata1_i + Imm_i) & 32'hFFFF_FFFE;
        end else if (Opcode_i == T_BRANCH) begin
            case (funct3_i)
                3'd0: tk = (Regdata1_i == Regdata2_i);
                3'd1: tk = (Regdata1_i != Regdata2_i);
                3'd4: tk = ($signed(Regdata1_i) < $signed(Regdata2_i));
                3'd5: tk = ($signed(Regdata1_i) >= $signed(Regdata2_i));
                3'd6: tk = (Regdata1_i < Regdata2_i);
                3'd7: tk = (Regdata1_i >= Regdata2_i);
                default: ill = 1;
            endcase
            ctl = !ill;
            if (tk) begin
                sel = 2'd1; tgt = PC_i + Imm_i;
            end
        end
        m_valid = 1; m_br = tk; m_sel = sel; m_tgt = tgt; m_link = PC_i + 32'd4;
        m_ill = ill;
        m_mis = ill ? 1'b0 : (tk != Pred_taken_i);
        if (ctl && m_brc < CMAX) m_brc++;
        if (m_mis && m_mpc < CMAX) m_mpc++;
        if (m_mis) m_flush_left = FLUSH;
    endtask

    // Called right after each rising edge with the inputs that were sampled on it.
    task automatic model_step();
        if (rst_i) begin
            model_reset();
        end else if (m_flush_left > 0) begin
            m_flush_left--;
            if (!Stall_i) m_valid = 0;
        end else if (!Stall_i) begin
            if (Valid_i) model_accept();
            else m_valid = 0;
        end
    endtask

    task automatic check_all();
        chk("Valid_o",         64'(Valid_o),         64'(m_valid));
        chk("Flush_o",         64'(Flush_o),         64'(m_flush_left > 0));
        chk("Br_count_o",      64'(Br_count_o),      64'(m_brc));
        chk("Mispred_count_o", 64'(Mispred_count_o), 64'(m_mpc));
        chk("Branch_en_o",     64'(Branch_en_o),     64'(m_br));
        chk("PC_mux_sel_o",    64'(PC_mux_sel_o),    64'(m_sel));
        chk("Target_o",        64'(Target_o),        64'(m_tgt));
        chk("Link_o",          64'(Link_o),          64'(m_link));
        chk("Mispredict_o",    64'(Mispredict_o),    64'(m_mis));
        chk("Illegal_o",       64'(Illegal_o),       64'(m_ill));
    endtask

    // One clock: check combinational Ready_o, clock, advance model, compare registered outputs.
    task automatic cyc();
        #1;
        if (!rst_i) chk("Ready_o", 64'(Ready_o), 64'((m_flush_left == 0) && !Stall_i));
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        check_all();
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] pc, input logic [31:0] imm,
                         input logic pred, input logic vld, input logic stall);
        Opcode_i = op; funct3_i = f3; Regdata1_i = rs1; Regdata2_i = rs2; PC_i = pc;
        Imm_i = imm; Pred_taken_i = pred; Valid_i = vld; Stall_i = stall;
    endtask

    task automatic idle();
        Valid_i = 0; Stall_i = 0;
    endtask

    initial begin
        model_reset();
        rst_i = 1;
        drive(T_ALU, 3'd0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        cyc();
        chk("reset Valid_o", 64'(Valid_o), 64'd0);
        chk("reset Br_count_o", 64'(Br_count_o), 64'd0);
        rst_i = 0;

        // BEQ taken, predicted taken
        drive(T_BRANCH, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1, 1, 0);
        cyc();
        chk("beq Target_o", 64'(Target_o), 64'h120);
        chk("beq sel", 64'(PC_mux_sel_o), 64'd1);
        chk("beq Br_count_o", 64'(Br_count_o), 64'd1);
        chk("beq Flush_o", 64'(Flush_o), 64'd0);
        idle();
        cyc();
        chk("idle Valid_o", 64'(Valid_o), 64'd0);

        // BLT signed: -1 < 1 taken
        drive(T_BRANCH, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1, 1, 0);
        cyc();
        chk("blt Branch_en_o", 64'(Branch_en_o), 64'd1);
        chk("blt Target_o", 64'(Target_o), 64'h210);

        // BLTU same operands: not taken, predicted taken -> mispredict and flush
        drive(T_BRANCH, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1, 1, 0);
        cyc();
        chk("bltu Branch_en_o", 64'(Branch_en_o), 64'd0);
        chk("bltu Target_o", 64'(Target_o), 64'h204);
        chk("bltu Mispredict_o", 64'(Mispredict_o), 64'd1);
        chk("bltu Flush_o c1", 64'(Flush_o), 64'd1);
        drive(T_JAL, 3'd0, 0, 0, 32'h300, 32'h8, 1, 1, 0);
        #1 chk("flush Ready_o", 64'(Ready_o), 64'd0);
        cyc();
        chk("bltu Flush_o c2", 64'(Flush_o), 64'd1);
        chk("flush Br_count_o", 64'(Br_count_o), 64'd3);
        cyc();
        chk("bltu Flush_o c3", 64'(Flush_o), 64'd0);
        idle();
        cyc();

        // JALR clears bit 0; JAL wraps
        drive(T_JALR, 3'd0, 32'h1001, 0, 32'h40, 32'h2, 1, 1, 0);
        cyc();
        chk("jalr Target_o", 64'(Target_o), 64'h1002);
        chk("jalr Link_o", 64'(Link_o), 64'h44);
        chk("jalr sel", 64'(PC_mux_sel_o), 64'd2);
        drive(T_JAL, 3'd0, 0, 0, 32'hFFFF_FFFC, 32'h8, 1, 1, 0);
        cyc();
        chk("jal wrap Target_o", 64'(Target_o), 64'h4);

        // Illegal funct3, then stall for 3 cycles
        drive(T_BRANCH, 3'd2, 32'd1, 32'd1, 32'h500, 32'h10, 1, 1, 0);
        cyc();
        chk("ill Illegal_o", 64'(Illegal_o), 64'd1);
        chk("ill Mispredict_o", 64'(Mispredict_o), 64'd0);
        chk("ill Br_count_o", 64'(Br_count_o), 64'd5);
        drive(T_BRANCH, 3'd0, 32'd1, 32'd1, 32'h600, 32'h10, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc();
        chk("stall Valid_o", 64'(Valid_o), 64'd1);
        chk("stall Illegal_o", 64'(Illegal_o), 64'd1);
        chk("stall Br_count_o", 64'(Br_count_o), 64'd5);

        // Reset in the middle of a flush
        drive(T_BRANCH, 3'd0, 32'd1, 32'd2, 32'h700, 32'h10, 1, 1, 0);
        cyc();
        chk("pre-rst Flush_o", 64'(Flush_o), 64'd1);
        rst_i = 1;
        cyc();
        rst_i = 0;
        idle();
        chk("rst Flush_o", 64'(Flush_o), 64'd0);
        chk("rst Mispred_count_o", 64'(Mispred_count_o), 64'd0);
        #1 chk("rst Ready_o", 64'(Ready_o), 64'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_i        = ($urandom_range(0, 299) == 0);
            Valid_i      = ($urandom_range(0, 9) < 7);
            Stall_i      = ($urandom_range(0, 9) < 2);
            case ($urandom_range(0, 5))
                0:       Opcode_i = T_JAL;
                1:       Opcode_i = T_JALR;
                2, 3:    Opcode_i = T_BRANCH;
                4:       Opcode_i = T_ALU;
                default: Opcode_i = 7'($urandom);
            endcase
            funct3_i     = 3'($urandom);
            Regdata1_i   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            Regdata2_i   = ($urandom_range(0, 2) == 0) ? Regdata1_i : $urandom;
            PC_i         = $urandom;
            Imm_i        = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
            Pred_taken_i = 1'($urandom);
            cyc();
        end
        rst_i = 0;

        // Saturation: more than 2^CW mispredicting legal branches from a clean reset
        rst_i = 1;
        idle();
        cyc();
        rst_i = 0;
        drive(T_BRANCH, 3'd0, 32'd1, 32'd2, 32'h800, 32'h10, 1, 1, 0);
        for (int i = 0; i < 3 * (CMAX + 20); i++) cyc();
        chk("sat Br_count_o", 64'(Br_count_o), 64'(CMAX));
        chk("sat Mispred_count_o", 64'(Mispred_count_o), 64'(CMAX));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/riscv_branch_unit.md
Name: riscv_branch_unit

Overview:
Registered branch/jump resolution stage that sits between the decode/regfile-read stage and the PC mux. It resolves all RV32I control-transfer instructions: JAL, JALR, BEQ, BNE, BLT, BGE, BLTU and BGEU. It compares the actual outcome with the fetch-stage prediction and generates a timed flush window on a mispredict. It also keeps saturating performance counters for branches and mispredicts.

Parameters:
DW, 32, register data width (matches `dw)
AW, 32, PC/target address width
FLUSH_CYCLES, 2, cycles Flush_o is held after a mispredict (>=1)
CW, 16, width of each performance counter

Ports:
clk_i  input  1  clock, all logic rising-edge
rst_i  input  1  synchronous reset, active-high
Valid_i  input  1  instruction fields below are valid
Ready_o  output  1  unit can accept an instruction this cycle
Opcode_i  input  7  instruction opcode
funct3_i  input  3  instruction funct3
Regdata1_i  input  DW  rs1 data
Regdata2_i  input  DW  rs2 data
PC_i  input  AW  PC of the instruction
Imm_i  input  DW  sign-extended immediate (B/J/I format already selected upstream)
Pred_taken_i  input  1  fetch predicted taken
Stall_i  input  1  downstream stall; hold output register
Valid_o  output  1  registered result valid
Branch_en_o  output  1  control transfer actually taken
PC_mux_sel_o  output  2  00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1, 11 unused
Target_o  output  AW  resolved target (PC_i+4 when not taken)
Link_o  output  AW  PC_i+4 (JAL/JALR writeback)
Mispredict_o  output  1  Branch_en_o != Pred_taken_i for a legal control op
Illegal_o  output  1  branch opcode with funct3 010 or 011
Flush_o  output  1  flush request to fetch/decode
Br_count_o  output  CW  legal control ops resolved
Mispred_count_o  output  CW  mispredicts

Behaviour:
- Reset (synchronous, rst_i=1 at clock edge): every registered output is 0 (Valid_o, Branch_en_o, PC_mux_sel_o=00, Target_o, Link_o, Mispredict_o, Illegal_o, Flush_o, both counters); FSM goes to RUN. Reset overrides all other inputs, including a flush in progress.
- Ready_o = (state==RUN) && !Stall_i. It is combinational from state and Stall_i.
- Accept = Valid_i && Ready_o. Latency 1: the result registers on the accept edge and is visible the next cycle.
- Stall_i=1: output register holds, counters hold, no accept.
- No accept and Stall_i=0: Valid_o=0; other result fields keep their last values.
- Non-control opcode accepted: Valid_o=1, Branch_en_o=0, PC_mux_sel_o=00, Target_o=PC_i+4, Mispredict_o=Pred_taken_i.
- Compare rules: BEQ/BNE use equality over DW bits; BLT/BGE use signed compare; BLTU/BGEU use unsigned compare.
- Target arithmetic: PC+imm and rs1+imm are computed mod 2^AW (wrap-around, no overflow flag). Imm_i is truncated or sign-extended to AW. JALR clears bit 0 of the target.
- JAL: taken, sel 01. JALR: taken, sel 10.
- Illegal branch (funct3 010/011): not taken, sel 00, Illegal_o=1, Mispredict_o=0, Br_count_o not incremented.
- FSM states: RUN and FLUSH.
  - RUN -> FLUSH on the accept edge that registers Mispredict=1. Flush_o goes to 1 in the same cycle as Mispredict_o, and a counter is loaded with FLUSH_CYCLES-1.
  - FLUSH: Ready_o=0 and Valid_i is ignored. The counter decrements each cycle; at 0, FLUSH -> RUN and Flush_o drops. Flush_o is therefore high for exactly FLUSH_CYCLES cycles.
  - Stall_i does not extend the flush.
  - FLUSH_CYCLES=1: the unit returns to RUN the next cycle.
- Counters: increment on the accept edge. Both saturate at all-ones and do not wrap.

Decomposition:
- Shared package/define file holds:
  - opcode constants OP_JAL=1101111, OP_JALR=1100111, OP_BRANCH=1100011
  - funct3 constants F3_BEQ..F3_BGEU
  - PC_mux_sel encodings SEL_PC4=00, SEL_PCIMM=01, SEL_RS1IMM=10
- One sub-module, riscv_branch_cmp: purely combinational; takes funct3 and rs1/rs2 and returns taken and illegal. The top module holds the FSM, the registers and the counters.

Test Plan:
- BEQ rs1=rs2=5, PC=0x100, imm=0x20, Pred=1 -> next cycle Valid_o=1, Branch_en_o=1, sel 01, Target_o=0x120, Mispredict_o=0, Flush_o=0, Br_count_o=1.
- BLT rs1=0xFFFFFFFF, rs2=1 -> taken. Same operands with BLTU -> not taken, Target_o=PC+4. Pred=1 on the BLTU -> Mispredict_o=1, Flush_o high for exactly 2 cycles, Ready_o=0 during those cycles, and a Valid_i during the flush is not accepted (Br_count_o unchanged).
- JALR rs1=0x1001, imm=0x2, PC=0x40 -> Target_o=0x1002 (bit 0 cleared), Link_o=0x44, sel 10. JAL with PC=0xFFFFFFFC, imm=8 -> Target_o=0x4 (wrap).
- Branch opcode with funct3=010 -> Illegal_o=1, Branch_en_o=0, Mispredict_o=0, counters unchanged. Stall_i=1 for 3 cycles mid-stream -> outputs and counters hold, Ready_o=0.
- Assert rst_i during the FLUSH state -> next cycle Flush_o=0, counters=0, Ready_o=1. Preload counters to all-ones via a long run -> counters stay at all-ones.
